// File: rtl/proc_pkg.sv
// Shared processor constants: module-select codes, arbiter state, widths.
package proc_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int ADDR_W_DEF = 12;

    localparam logic [3:0] MainMemEn    = 4'd0;
    localparam logic [3:0] InstrMemEn   = 4'd1;
    localparam logic [3:0] MatrixAluEn  = 4'd2;
    localparam logic [3:0] IntegerAluEn = 4'd3;
    localparam logic [3:0] ExecuteEn    = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request after last winner.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic            any_o,
    output logic [IW-1:0]   winner_o
);

    logic          hi_found;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Descending scan leaves the lowest index above and at-or-below last.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                if (IW'(j) > last_i) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(j);
                end else begin
                    lo_idx = IW'(j);
                end
            end
        end
        any_o    = |req_i;
        winner_o = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing the Main Memory port among NREQ requesters.
module main_mem_arbiter
    import proc_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     Clk,
    input  logic                     nReset,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ-1:0]          ReqWrite,
    input  logic [NREQ*ADDR_W-1:0]   ReqAddr,
    input  logic [NREQ*DATA_W-1:0]   ReqData,
    output logic [NREQ-1:0]          Grant,
    output logic [NREQ-1:0]          Done,
    output logic [DATA_W-1:0]        RdData,
    output logic [15:0]              address,
    output logic                     nRead,
    output logic                     nWrite,
    output logic [DATA_W-1:0]        MemDataIn,
    input  logic [DATA_W-1:0]        MemDataOut
);

    localparam int IW = $clog2(NREQ);

    arb_state_e        state_q;
    logic [IW-1:0]     last_q;
    logic              wr_q;

    logic              any;
    logic [IW-1:0]     pick;
    logic [NREQ-1:0]   sel_gnt;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i    (Req),
        .last_i   (last_q),
        .any_o    (any),
        .winner_o (pick)
    );

    always_comb begin
        sel_gnt  = '0;
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick == IW'(j)) begin
                sel_gnt[j] = 1'b1;
                sel_wr     = ReqWrite[j];
                sel_addr   = ReqAddr[j*ADDR_W +: ADDR_W];
                sel_data   = ReqData[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            last_q    <= IW'(NREQ - 1);
            wr_q      <= 1'b0;
            Grant     <= '0;
            Done      <= '0;
            RdData    <= '0;
            address   <= '0;
            nRead     <= 1'b1;
            nWrite    <= 1'b1;
            MemDataIn <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    Done <= '0;
                    if (any) begin
                        state_q   <= ACCESS;
                        last_q    <= pick;
                        wr_q      <= sel_wr;
                        Grant     <= sel_gnt;
                        address   <= {MainMemEn, 12'(sel_addr)};
                        nRead     <= sel_wr;
                        nWrite    <= !sel_wr;
                        MemDataIn <= sel_wr ? sel_data : '0;
                    end
                end
                ACCESS: begin
                    if (!wr_q) begin
                        RdData <= MemDataOut;
                    end
                    // Grant still holds the one-hot winner, reuse it for Done.
                    Done      <= Grant;
                    Grant     <= '0;
                    address   <= '0;
                    nRead     <= 1'b1;
                    nWrite    <= 1'b1;
                    MemDataIn <= '0;
                    state_q   <= DONE;
                end
                DONE: begin
                    Done    <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
